// File: rtl/process_engine.sv
// process_engine: one process slot that executes a loadable program, one instruction per clock.
// Execution starts at pc 0 and ends on HALT, an illegal opcode, the step limit or running off program memory.
module process_engine #(
    parameter int WIDTH     = 8,
    parameter int NREGS     = 16,
    parameter int DEPTH     = 32,
    parameter int MAX_STEPS = 100,
    localparam int RA = $clog2(NREGS),
    localparam int PA = $clog2(DEPTH),
    localparam int IW = 4 + 3*RA + WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             prog_we,
    input  logic [PA-1:0]    prog_addr,
    input  logic [IW-1:0]    prog_data,
    input  logic             start,
    output logic             running,
    output logic             stop,
    output logic [PA:0]      pc,
    output logic [1:0]       rc,
    output logic [31:0]      steps,
    input  logic [RA-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Handshake: start is a one-cycle request, accepted only in IDLE or DONE. stop stays high
    // in DONE until the next accepted start; rc, pc, steps and registers are valid while stop=1.

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_SET  = 4'd1;
    localparam logic [3:0] OP_MOV  = 4'd2;
    localparam logic [3:0] OP_GE   = 4'd3;
    localparam logic [3:0] OP_GT   = 4'd4;
    localparam logic [3:0] OP_LE   = 4'd5;
    localparam logic [3:0] OP_LT   = 4'd6;
    localparam logic [3:0] OP_NE   = 4'd7;
    localparam logic [3:0] OP_EQ   = 4'd8;
    localparam logic [3:0] OP_ADD  = 4'd9;
    localparam logic [3:0] OP_JMP  = 4'd10;
    localparam logic [3:0] OP_JZ   = 4'd11;
    localparam logic [3:0] OP_JNZ  = 4'd12;
    localparam logic [3:0] OP_HALT = 4'd13;

    localparam logic [1:0] RC_OK      = 2'd0;
    localparam logic [1:0] RC_LIMIT   = 2'd1;
    localparam logic [1:0] RC_ILLEGAL = 2'd2;

    state_t           state;
    logic [IW-1:0]    prog_mem [DEPTH];
    logic [WIDTH-1:0] regs [NREGS];

    logic [IW-1:0]    instr;
    logic [3:0]       op;
    logic [RA-1:0]    dst;
    logic [RA-1:0]    src1;
    logic [RA-1:0]    src2;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [PA:0]      jump_target;
    logic [PA:0]      pc_seq;
    logic [PA:0]      pc_next;
    logic [31:0]      steps_next;
    logic             at_end;
    logic             limit_hit;
    logic             wr_en;
    logic [WIDTH-1:0] wr_val;
    logic             halt_req;
    logic             illegal;

    assign instr       = prog_mem[pc[PA-1:0]];
    assign op          = instr[IW-1 -: 4];
    assign dst         = instr[IW-5 -: RA];
    assign src1        = instr[IW-5-RA -: RA];
    assign src2        = instr[IW-5-2*RA -: RA];
    assign imm         = instr[WIDTH-1:0];
    assign opa         = regs[src1];
    assign opb         = regs[src2];
    assign at_end      = pc[PA];
    assign jump_target = {1'b0, imm[PA-1:0]};
    assign pc_seq      = pc + (PA+1)'(1);
    assign steps_next  = steps + 32'd1;
    assign limit_hit   = (steps_next == 32'(MAX_STEPS));
    assign rd_data     = regs[rd_addr];

    function automatic logic [WIDTH-1:0] flag(input logic b);
        return {{(WIDTH-1){1'b0}}, b};
    endfunction

    // Decode and execute the instruction at pc using the pre-edge register values.
    always_comb begin
        wr_en    = 1'b0;
        wr_val   = '0;
        pc_next  = pc_seq;
        halt_req = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_NOP:  ;
            OP_SET:  begin wr_en = 1'b1; wr_val = imm; end
            OP_MOV:  begin wr_en = 1'b1; wr_val = opa; end
            OP_GE:   begin wr_en = 1'b1; wr_val = flag(opa >= opb); end
            OP_GT:   begin wr_en = 1'b1; wr_val = flag(opa >  opb); end
            OP_LE:   begin wr_en = 1'b1; wr_val = flag(opa <= opb); end
            OP_LT:   begin wr_en = 1'b1; wr_val = flag(opa <  opb); end
            OP_NE:   begin wr_en = 1'b1; wr_val = flag(opa != opb); end
            OP_EQ:   begin wr_en = 1'b1; wr_val = flag(opa == opb); end
            OP_ADD:  begin wr_en = 1'b1; wr_val = opa + opb; end
            OP_JMP:  pc_next = jump_target;
            OP_JZ:   if (opa == '0) pc_next = jump_target;
            OP_JNZ:  if (opa != '0) pc_next = jump_target;
            OP_HALT: begin halt_req = 1'b1; pc_next = pc; end
            default: begin illegal = 1'b1; pc_next = pc; end
        endcase
    end

    // Writes are refused while a program is running so the executing image never changes.
    always_ff @(posedge clock) begin
        if (prog_we && state != S_RUN) begin
            prog_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            rc      <= RC_OK;
            steps   <= '0;
            running <= 1'b0;
            stop    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_RUN;
                        pc      <= '0;
                        rc      <= RC_OK;
                        steps   <= '0;
                        running <= 1'b1;
                        stop    <= 1'b0;
                        for (int i = 0; i < NREGS; i++) begin
                            regs[i] <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (at_end) begin
                        // Fell off the end of program memory: normal completion, nothing executed.
                        state   <= S_DONE;
                        rc      <= RC_OK;
                        running <= 1'b0;
                        stop    <= 1'b1;
                    end else begin
                        steps <= steps_next;
                        pc    <= pc_next;
                        if (wr_en) begin
                            regs[dst] <= wr_val;
                        end
                        // An explicit halt outcome takes priority over the step limit.
                        if (halt_req || illegal) begin
                            state   <= S_DONE;
                            rc      <= illegal ? RC_ILLEGAL : RC_OK;
                            running <= 1'b0;
                            stop    <= 1'b1;
                        end else if (limit_hit) begin
                            state   <= S_DONE;
                            rc      <= RC_LIMIT;
                            running <= 1'b0;
                            stop    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                    stop    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_process_engine.sv
// Bench for process_engine: default-size instance plus a 16-bit, 4-entry instance for width and fall-off cases.
module tb_process_engine;

    localparam int W = 8, NR = 16, D = 32, MS = 100, RA = 4, PA = 5, IW = 24;
    localparam int BW = 16, BNR = 4, BD = 4, BRA = 2, BPA = 2, BIW = 26;
    localparam int EW = 48;

    localparam int K_RC = 0, K_PC = 1, K_STEPS = 2, K_REG = 3, K_CYC = 4, K_RUN = 5, K_STOP = 6;
    localparam int OP_NOP = 0, OP_SET = 1, OP_MOV = 2, OP_GE = 3, OP_GT = 4, OP_LE = 5, OP_LT = 6;
    localparam int OP_NE = 7, OP_EQ = 8, OP_ADD = 9, OP_JMP = 10, OP_JZ = 11, OP_JNZ = 12, OP_HALT = 13;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, prog_we, start;
    logic [PA-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic [RA-1:0] rd_addr;
    logic          running, stop;
    logic [PA:0]   pc;
    logic [1:0]    rc;
    logic [31:0]   steps;
    logic [W-1:0]  rd_data;

    logic           b_reset, b_prog_we, b_start;
    logic [BPA-1:0] b_prog_addr;
    logic [BIW-1:0] b_prog_data;
    logic [BRA-1:0] b_rd_addr;
    logic           b_running, b_stop;
    logic [BPA:0]   b_pc;
    logic [1:0]     b_rc;
    logic [31:0]    b_steps;
    logic [BW-1:0]  b_rd_data;

    process_engine #(.WIDTH(W), .NREGS(NR), .DEPTH(D), .MAX_STEPS(MS)) dut_a (
        .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .running(running), .stop(stop), .pc(pc),
        .rc(rc), .steps(steps), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    process_engine #(.WIDTH(BW), .NREGS(BNR), .DEPTH(BD), .MAX_STEPS(MS)) dut_b (
        .clock(clock), .reset(b_reset), .prog_we(b_prog_we), .prog_addr(b_prog_addr),
        .prog_data(b_prog_data), .start(b_start), .running(b_running), .stop(b_stop), .pc(b_pc),
        .rc(b_rc), .steps(b_steps), .rd_addr(b_rd_addr), .rd_data(b_rd_data)
    );

    int    n_checks = 0;
    int    n_fail = 0;
    int    last_cyc = 0;
    string cur_test = "init";

    logic [EW-1:0]  exp_q[$];
    logic [IW-1:0]  prog_a[$];
    logic [BIW-1:0] prog_b[$];

    logic          launch_we = 1'b0;
    logic [PA-1:0] launch_addr = '0;
    logic [IW-1:0] launch_data = '0;
    int            poke_at = -1;
    logic          poke_start = 1'b0, poke_we = 1'b0;
    logic [PA-1:0] poke_addr = '0;
    logic [IW-1:0] poke_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] enc_a(input int op, input int dst, input int s1, input int s2, input int imm);
        return {op[3:0], dst[RA-1:0], s1[RA-1:0], s2[RA-1:0], imm[W-1:0]};
    endfunction

    function automatic logic [BIW-1:0] enc_b(input int op, input int dst, input int s1, input int s2, input int imm);
        return {op[3:0], dst[BRA-1:0], s1[BRA-1:0], s2[BRA-1:0], imm[BW-1:0]};
    endfunction

    function automatic void pa(input int op, input int dst, input int s1, input int s2, input int imm);
        prog_a.push_back(enc_a(op, dst, s1, s2, imm));
    endfunction

    function automatic void exp_push(input int sel, input int kind, input int idx, input logic [31:0] val);
        exp_q.push_back({sel[3:0], kind[3:0], idx[7:0], val});
    endfunction

    function automatic void exp_done(input int sel, input int erc, input int epc, input int esteps, input int ecyc);
        exp_push(sel, K_RC, 0, erc);
        exp_push(sel, K_PC, 0, epc);
        exp_push(sel, K_STEPS, 0, esteps);
        exp_push(sel, K_CYC, 0, ecyc);
        exp_push(sel, K_STOP, 0, 1);
        exp_push(sel, K_RUN, 0, 0);
    endfunction

    function automatic void exp_reg(input int sel, input int idx, input int val);
        exp_push(sel, K_REG, idx, val);
    endfunction

    task automatic drain();
        logic [EW-1:0] e;
        logic [31:0]   obs;
        int            sel, kind, idx;
        string         names[7] = '{"rc", "pc", "steps", "reg", "cyc", "running", "stop"};
        while (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            sel  = int'(e[47:44]);
            kind = int'(e[43:40]);
            idx  = int'(e[39:32]);
            obs  = '0;
            case (kind)
                K_RC:    obs = (sel == 0) ? 32'(rc) : 32'(b_rc);
                K_PC:    obs = (sel == 0) ? 32'(pc) : 32'(b_pc);
                K_STEPS: obs = (sel == 0) ? steps : b_steps;
                K_CYC:   obs = 32'(last_cyc);
                K_RUN:   obs = (sel == 0) ? 32'(running) : 32'(b_running);
                K_STOP:  obs = (sel == 0) ? 32'(stop) : 32'(b_stop);
                default: begin
                    if (sel == 0) rd_addr = idx[RA-1:0];
                    else b_rd_addr = idx[BRA-1:0];
                    #1;
                    obs = (sel == 0) ? 32'(rd_data) : 32'(b_rd_data);
                end
            endcase
            check_eq($sformatf("%s/%s%0d", cur_test, names[kind], idx), obs, e[31:0]);
        end
    endtask

    task automatic load_prog(input int sel);
        if (sel == 0) begin
            foreach (prog_a[i]) begin
                @(negedge clock);
                prog_we = 1'b1; prog_addr = i[PA-1:0]; prog_data = prog_a[i];
            end
            @(negedge clock);
            prog_we = 1'b0;
        end else begin
            foreach (prog_b[i]) begin
                @(negedge clock);
                b_prog_we = 1'b1; b_prog_addr = i[BPA-1:0]; b_prog_data = prog_b[i];
            end
            @(negedge clock);
            b_prog_we = 1'b0;
        end
    endtask

    task automatic run_prog(input int sel, input int budget);
        logic done;
        @(negedge clock);
        if (sel == 0) begin
            start = 1'b1;
            if (launch_we) begin
                prog_we = 1'b1; prog_addr = launch_addr; prog_data = launch_data;
            end
        end else begin
            b_start = 1'b1;
        end
        @(negedge clock);
        start = 1'b0; prog_we = 1'b0; b_start = 1'b0; launch_we = 1'b0;
        last_cyc = 0;
        done = (sel == 0) ? stop : b_stop;
        while (!done && last_cyc < budget) begin
            if (sel == 0 && last_cyc == poke_at) begin
                start = poke_start; prog_we = poke_we; prog_addr = poke_addr; prog_data = poke_data;
            end else begin
                start = 1'b0; prog_we = 1'b0;
            end
            @(negedge clock);
            last_cyc++;
            done = (sel == 0) ? stop : b_stop;
        end
        start = 1'b0; prog_we = 1'b0; poke_at = -1;
        check_eq({cur_test, "/finished"}, 32'(done), 32'd1);
        repeat (2) @(negedge clock);
        drain();
    endtask

    task automatic load_countdown();
        prog_a = {};
        pa(OP_SET, 0, 0, 0, 5);
        pa(OP_SET, 1, 0, 0, 8'hFF);
        pa(OP_ADD, 0, 0, 1, 0);
        pa(OP_JNZ, 0, 0, 0, 2);
        pa(OP_HALT, 0, 0, 0, 0);
        load_prog(0);
    endtask

    function automatic void exp_countdown();
        exp_done(0, 0, 4, 13, 13);
        exp_reg(0, 0, 0);
        exp_reg(0, 1, 8'hFF);
        exp_reg(0, 2, 0);
    endfunction

    initial begin
        reset = 1'b1; prog_we = 1'b0; start = 1'b0; prog_addr = '0; prog_data = '0; rd_addr = '0;
        b_reset = 1'b1; b_prog_we = 1'b0; b_start = 1'b0; b_prog_addr = '0; b_prog_data = '0; b_rd_addr = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0; b_reset = 1'b0;

        cur_test = "reset";
        for (int s = 0; s < 2; s++) begin
            exp_push(s, K_RUN, 0, 0); exp_push(s, K_STOP, 0, 0); exp_push(s, K_PC, 0, 0);
            exp_push(s, K_RC, 0, 0); exp_push(s, K_STEPS, 0, 0); exp_reg(s, 0, 0); exp_reg(s, 3, 0);
        end
        drain();

        // Compares that all come out 0; HALT word written on the same edge as start.
        cur_test = "cmp_zero";
        prog_a = {};
        pa(OP_SET, 0, 0, 0, 0); pa(OP_SET, 1, 0, 0, 1); pa(OP_SET, 2, 0, 0, 2); pa(OP_SET, 3, 0, 0, 3);
        pa(OP_GE, 4, 0, 1, 0);  pa(OP_GT, 5, 0, 1, 0);  pa(OP_LE, 6, 1, 0, 0);  pa(OP_LT, 7, 1, 0, 0);
        pa(OP_NE, 8, 0, 0, 0);  pa(OP_EQ, 9, 0, 1, 0);
        load_prog(0);
        launch_we = 1'b1; launch_addr = 5'd10; launch_data = enc_a(OP_HALT, 0, 0, 0, 0);
        exp_done(0, 0, 10, 11, 11);
        for (int r = 0; r < 4; r++) exp_reg(0, r, r);
        for (int r = 4; r < 10; r++) exp_reg(0, r, 0);
        run_prog(0, 200);

        cur_test = "cmp_one";
        prog_a = {};
        pa(OP_SET, 0, 0, 0, 0); pa(OP_SET, 1, 0, 0, 1); pa(OP_GE, 2, 1, 0, 0); pa(OP_GT, 3, 1, 0, 0);
        pa(OP_LE, 4, 0, 1, 0);  pa(OP_LT, 5, 0, 1, 0);  pa(OP_NE, 6, 0, 1, 0); pa(OP_EQ, 7, 1, 1, 0);
        pa(OP_MOV, 8, 1, 0, 0); pa(OP_SET, 9, 0, 0, 8'hFF); pa(OP_GE, 10, 9, 1, 0); pa(OP_GE, 11, 1, 1, 0);
        pa(OP_LE, 12, 1, 1, 0); pa(OP_GT, 13, 1, 1, 0); pa(OP_LT, 14, 1, 1, 0); pa(OP_HALT, 0, 0, 0, 0);
        load_prog(0);
        exp_done(0, 0, 15, 16, 16);
        for (int r = 2; r < 9; r++) exp_reg(0, r, 1);
        exp_reg(0, 9, 8'hFF); exp_reg(0, 10, 1); exp_reg(0, 11, 1); exp_reg(0, 12, 1);
        exp_reg(0, 13, 0); exp_reg(0, 14, 0);
        run_prog(0, 200);

        cur_test = "countdown";
        load_countdown();
        exp_countdown();
        run_prog(0, 200);

        cur_test = "wrap_jumps";
        prog_a = {};
        pa(OP_SET, 0, 0, 0, 8'hFF); pa(OP_SET, 1, 0, 0, 2); pa(OP_ADD, 2, 0, 1, 0); pa(OP_ADD, 0, 0, 0, 0);
        pa(OP_JZ, 0, 3, 0, 6); pa(OP_SET, 4, 0, 0, 8'h77); pa(OP_JZ, 0, 2, 0, 8); pa(OP_SET, 5, 0, 0, 8'h55);
        pa(OP_JNZ, 0, 3, 0, 0); pa(OP_HALT, 0, 0, 0, 0);
        load_prog(0);
        exp_done(0, 0, 9, 9, 9);
        exp_reg(0, 0, 8'hFE); exp_reg(0, 1, 2); exp_reg(0, 2, 1); exp_reg(0, 4, 0); exp_reg(0, 5, 8'h55);
        run_prog(0, 200);

        cur_test = "step_limit";
        prog_a = {};
        pa(OP_JMP, 0, 0, 0, 0);
        load_prog(0);
        exp_done(0, 1, 0, 100, 100);
        run_prog(0, 200);

        cur_test = "illegal14";
        prog_a = {};
        pa(OP_NOP, 0, 0, 0, 0); pa(OP_NOP, 0, 0, 0, 0); pa(OP_SET, 1, 0, 0, 9); pa(14, 1, 0, 0, 8'h33);
        load_prog(0);
        exp_done(0, 2, 3, 4, 4);
        exp_reg(0, 1, 9);
        run_prog(0, 200);

        cur_test = "illegal15";
        prog_a = {};
        pa(15, 2, 0, 0, 8'h44);
        load_prog(0);
        exp_done(0, 2, 0, 1, 1);
        exp_reg(0, 2, 0);
        run_prog(0, 200);

        // HALT lands exactly on the 100th step: the halt result must win over the limit.
        cur_test = "halt_at_limit";
        prog_a = {};
        pa(OP_NOP, 0, 0, 0, 0); pa(OP_SET, 0, 0, 0, 48); pa(OP_SET, 1, 0, 0, 8'hFF);
        pa(OP_ADD, 0, 0, 1, 0); pa(OP_JNZ, 0, 0, 0, 3); pa(OP_HALT, 0, 0, 0, 0);
        load_prog(0);
        exp_done(0, 0, 5, 100, 100);
        exp_reg(0, 0, 0);
        run_prog(0, 200);

        cur_test = "we_start_in_run";
        load_countdown();
        poke_at = 2; poke_start = 1'b1; poke_we = 1'b1; poke_addr = 5'd4; poke_data = enc_a(OP_JMP, 0, 0, 0, 4);
        exp_countdown();
        run_prog(0, 200);

        cur_test = "rerun";
        exp_countdown();
        run_prog(0, 200);

        cur_test = "mid_reset";
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_push(0, K_RUN, 0, 0); exp_push(0, K_STOP, 0, 0); exp_push(0, K_PC, 0, 0);
        exp_push(0, K_STEPS, 0, 0); exp_push(0, K_RC, 0, 0); exp_reg(0, 0, 0); exp_reg(0, 1, 0);
        drain();

        cur_test = "after_reset";
        exp_countdown();
        run_prog(0, 200);

        // 16-bit, 4-entry instance: unsigned compare at full width, wrap to zero, fall off the end.
        cur_test = "b_width";
        prog_b = {};
        prog_b.push_back(enc_b(OP_SET, 0, 0, 0, 16'hFFFF));
        prog_b.push_back(enc_b(OP_SET, 1, 0, 0, 1));
        prog_b.push_back(enc_b(OP_GT, 2, 0, 1, 0));
        prog_b.push_back(enc_b(OP_ADD, 3, 0, 1, 0));
        load_prog(1);
        exp_done(1, 0, 4, 4, 5);
        exp_reg(1, 0, 16'hFFFF); exp_reg(1, 1, 1); exp_reg(1, 2, 1); exp_reg(1, 3, 0);
        run_prog(1, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
